// File: rtl/lane_game_if.sv
// Signal bundle between the lane game sequencer and the playfield datapaths.
// The sequencer is the slave side; the playfield/environment is the master side.
interface lane_game_if;
  logic        start;
  logic [3:0]  frog_row;
  logic [3:0]  frog_col;
  logic [15:0] lane_occ;
  logic        shift_en;
  logic [1:0]  difficulty;
  logic        lane_reload;
  logic        frog_home;
  logic [1:0]  lives;
  logic [2:0]  state;
  logic        game_over;
  logic        game_won;

  modport master (
    output start, frog_row, frog_col, lane_occ,
    input  shift_en, difficulty, lane_reload, frog_home, lives, state, game_over, game_won
  );

  modport slave (
    input  start, frog_row, frog_col, lane_occ,
    output shift_en, difficulty, lane_reload, frog_home, lives, state, game_over, game_won
  );
endinterface

// File: rtl/lane_game_sequencer.sv
// Game sequencer for the car-lane playfield: shift strobe timing, collision
// detection, lives/level tracking and reload pulses for lanes and frog.
module lane_game_sequencer #(
  parameter int INT0        = 1000,
  parameter int INT1        = 500,
  parameter int INT2        = 200,
  parameter int INT3        = 100,
  parameter int HOLD_CYCLES = 50,
  parameter int LIVES_INIT  = 3
) (
  input logic       clk,
  input logic       reset,
  lane_game_if.slave gi
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_LEVEL = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] count_r;
  logic [15:0] interval_s;
  logic [1:0]  lives_r;
  logic [1:0]  difficulty_r;
  logic        win_pend_r;
  logic        shift_en_r;
  logic        lane_reload_r;
  logic        frog_home_r;
  logic        game_over_r;
  logic        game_won_r;
  logic        hit_s;
  logic        tick_wrap_s;
  logic        hold_done_s;
  logic        restart_s;

  // Shift interval selection, collision and counter terminal conditions.
  always_comb begin
    case (difficulty_r)
      2'd0:    interval_s = 16'(INT0);
      2'd1:    interval_s = 16'(INT1);
      2'd2:    interval_s = 16'(INT2);
      default: interval_s = 16'(INT3);
    endcase
    hit_s       = gi.lane_occ[gi.frog_col] && (gi.frog_row != 4'd0) && (gi.frog_row != 4'd15);
    tick_wrap_s = (count_r == (interval_s - 16'd1));
    hold_done_s = (count_r == 16'(HOLD_CYCLES - 1));
  end

  // Next-state logic; restart_s marks a fresh game from IDLE/OVER/WIN.
  always_comb begin
    next_state_s = state_r;
    restart_s    = 1'b0;
    case (state_r)
      S_IDLE, S_OVER, S_WIN: begin
        if (gi.start) begin
          next_state_s = S_PLAY;
          restart_s    = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      S_PLAY: begin
        // Reaching the goal row wins over a same-cycle collision.
        if (gi.frog_row == 4'd0) begin
          next_state_s = S_LEVEL;
        end else if (hit_s) begin
          next_state_s = S_HIT;
        end else begin
          next_state_s = S_PLAY;
        end
      end
      S_HIT: begin
        if (lives_r == 2'd0) begin
          next_state_s = S_OVER;
        end else if (hold_done_s) begin
          next_state_s = S_PLAY;
        end else begin
          next_state_s = S_HIT;
        end
      end
      S_LEVEL: begin
        if (win_pend_r) begin
          next_state_s = S_WIN;
        end else if (hold_done_s) begin
          next_state_s = S_PLAY;
        end else begin
          next_state_s = S_LEVEL;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State, counters, game bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      count_r       <= 16'd0;
      lives_r       <= 2'(LIVES_INIT);
      difficulty_r  <= 2'd0;
      win_pend_r    <= 1'b0;
      shift_en_r    <= 1'b0;
      lane_reload_r <= 1'b0;
      frog_home_r   <= 1'b0;
      game_over_r   <= 1'b0;
      game_won_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;

      // One shared counter: shift ticks in PLAY, hold time in HIT/LEVEL.
      if (next_state_s != state_r) begin
        count_r <= 16'd0;
      end else if ((state_r == S_PLAY) && tick_wrap_s) begin
        count_r <= 16'd0;
      end else if ((state_r == S_PLAY) || (state_r == S_HIT) || (state_r == S_LEVEL)) begin
        count_r <= count_r + 16'd1;
      end else begin
        count_r <= 16'd0;
      end

      // Lanes stay frozen on the edge that leaves PLAY.
      shift_en_r    <= (state_r == S_PLAY) && (next_state_s == S_PLAY) && tick_wrap_s;
      frog_home_r   <= (state_r != S_PLAY) && (next_state_s == S_PLAY);
      lane_reload_r <= (state_r != S_PLAY) && (state_r != S_HIT) && (next_state_s == S_PLAY);

      if (restart_s) begin
        lives_r      <= 2'(LIVES_INIT);
        difficulty_r <= 2'd0;
      end else if ((state_r == S_PLAY) && (next_state_s == S_HIT) && (lives_r != 2'd0)) begin
        lives_r <= lives_r - 2'd1;
      end else if ((state_r == S_PLAY) && (next_state_s == S_LEVEL) && (difficulty_r != 2'd3)) begin
        difficulty_r <= difficulty_r + 2'd1;
      end

      if ((state_r == S_PLAY) && (next_state_s == S_LEVEL)) begin
        win_pend_r <= (difficulty_r == 2'd3);
      end

      game_over_r <= (next_state_s == S_OVER);
      game_won_r  <= (next_state_s == S_WIN);
    end
  end

  assign gi.shift_en    = shift_en_r;
  assign gi.difficulty  = difficulty_r;
  assign gi.lane_reload = lane_reload_r;
  assign gi.frog_home   = frog_home_r;
  assign gi.lives       = lives_r;
  assign gi.state       = state_r;
  assign gi.game_over   = game_over_r;
  assign gi.game_won    = game_won_r;

endmodule

// File: doc/lane_game_sequencer.md
Name: lane_game_sequencer

Overview:
Top-level game sequencer for the car-lane LED playfield. It generates the lane shift strobe at a rate set by the current difficulty and detects frog/car collisions from the occupancy row under the frog. It tracks lives and level progression through a small FSM, and issues reload pulses to the lane and frog datapaths. It sits between the lane shift-register block, which consumes shift_en, difficulty and lane_reload, and the frog position controller.

Parameters:
INT0, 1000, shift interval in clk cycles at difficulty 0
INT1, 500, shift interval at difficulty 1
INT2, 200, shift interval at difficulty 2
INT3, 100, shift interval at difficulty 3
HOLD_CYCLES, 50, cycles spent in HIT and LEVEL before resuming play
LIVES_INIT, 3, lives loaded at game start (1..3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level-sensitive start/restart request
frog_row  in  4  frog row; 15 = start row (safe), 0 = goal row (safe)
frog_col  in  4  frog column
lane_occ  in  16  car occupancy of the lane at frog_row, bit i = column i
shift_en  out  1  one-cycle pulse; lanes rotate by one on this cycle
difficulty  out  2  current level 0..3
lane_reload  out  1  one-cycle pulse; lanes reload their initial patterns
frog_home  out  1  one-cycle pulse; frog returns to row 15
lives  out  2  remaining lives
state  out  3  IDLE=0, PLAY=1, HIT=2, LEVEL=3, OVER=4, WIN=5
game_over  out  1  high while in OVER
game_won  out  1  high while in WIN

Behaviour:
- Reset: state=IDLE, difficulty=0, lives=LIVES_INIT, counters=0, shift_en=lane_reload=frog_home=game_over=game_won=0.
- All outputs are registered. Pulse outputs are high for exactly one cycle.
- Interval mux: interval = INT0..INT3 selected by difficulty. Counters are 16 bit.
- Tick counter runs only in PLAY. It counts 0..interval-1. shift_en=1 on the cycle after count==interval-1, and the count returns to 0. First shift_en comes interval cycles after entering PLAY.
- Tick counter clears to 0 on every entry to PLAY. It never free-runs in other states.
- Collision is hit = lane_occ[frog_col] && frog_row!=0 && frog_row!=15, evaluated every PLAY cycle, including a shift_en cycle.
- IDLE: when start=1, go to PLAY and pulse lane_reload and frog_home; lives=LIVES_INIT, difficulty=0.
- PLAY, priority order:
  - frog_row==0 → LEVEL.
  - else hit → HIT.
  - else stay in PLAY.
  - Goal takes precedence over a same-cycle collision.
- HIT: on entry, lives decrements by one.
  - If the decremented value is 0, go to OVER next cycle. No hold is applied.
  - Otherwise hold for HOLD_CYCLES cycles with no shifts. Then pulse frog_home and return to PLAY. Lanes are not reloaded.
- LEVEL:
  - If difficulty==3, go to WIN next cycle.
  - Otherwise difficulty increments on entry, then hold for HOLD_CYCLES cycles. Then pulse lane_reload and frog_home and go to PLAY.
- OVER/WIN: outputs are frozen and game_over or game_won is high.
  - start=1 goes to PLAY with the same actions as IDLE→PLAY.
  - start held high across the transition does not retrigger anything; start is ignored in PLAY, HIT and LEVEL.
- lives never underflows. difficulty saturates at 3 and cannot exceed it.
- reset in any state, mid-count or mid-hold, restores the reset values on the next edge. No pulse is emitted on that cycle.

Test Plan:
- Reset, start=1 for 1 cycle, difficulty 0, no cars → state=1; lane_reload and frog_home pulse once; first shift_en 1000 cycles after PLAY entry, then every 1000 cycles.
- In PLAY: frog_row=7, frog_col=4, lane_occ=16'h0010 → HIT; lives 3→2; no shift_en for 50 cycles; then frog_home pulses and state=1.
- Three collisions from lives=3 → lives reaches 0, state=4, game_over=1; start=1 → state=1, lives=3, difficulty=0.
- frog_row=0 at difficulty 0 → LEVEL, difficulty=1; after 50 cycles lane_reload pulses; shift_en spacing becomes 500. Repeat through difficulty 3: spacing 200, then 100; the next goal → state=5, game_won=1.
- Same cycle frog_row=0 and lane_occ=16'hFFFF → LEVEL taken, lives unchanged.
- Assert reset at count 600 in PLAY and mid-HIT hold → next cycle state=0, lives=3, difficulty=0, no shift_en.
